// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline run controller.
//   - Command codes driven on i_cmd.
//   - Controller state encodings (also exported on o_state for debug).
//   - Default halt instruction encoding.
//   - state_flags(): decodes a state into its {busy, cmd_ready, pipe_en} outputs.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_LOAD = 3'd1,
    CMD_RUN  = 3'd2,
    CMD_STEP = 3'd3,
    CMD_STOP = 3'd4,
    CMD_DUMP = 3'd5
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_STEP  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DUMP  = 3'd5
  } state_e;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  // Output flags that depend only on the state being entered:
  // [2] busy, [1] command ready, [0] pipeline enable.
  function automatic logic [2:0] state_flags(input state_e s);
    logic busy;
    logic ready;
    logic pipe_en;
    busy    = (s != ST_IDLE);
    ready   = (s == ST_IDLE) || (s == ST_RUN);
    pipe_en = (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    return {busy, ready, pipe_en};
  endfunction

endpackage

// File: rtl/dump_seq.sv
// Dump index sequencer.
// Streams indices 0..DUMP_WORDS-1 with a valid/ready handshake, one index per
// accepted transfer, then stops (no wrap).
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   start        : begin a new dump at index 0 (valid rises next cycle)
//   ready        : consumer accepts the current index
//   valid        : registered index valid
//   idx          : registered index
//   done         : strobe, high in the cycle the final index is accepted
module dump_seq
  #(parameter int DUMP_WORDS = 96)
  (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       start,
    input  logic       ready,
    output logic       valid,
    output logic [6:0] idx,
    output logic       done
  );

  localparam logic [6:0] LAST_IDX = 7'(DUMP_WORDS - 1);

  logic       valid_reg;
  logic [6:0] idx_reg;

  // Lets the parent leave its dump state on the same edge valid drops.
  assign done  = valid_reg && ready && (idx_reg == LAST_IDX);
  assign valid = valid_reg;
  assign idx   = idx_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_reg <= 1'b0;
      idx_reg   <= '0;
    end else if (start) begin
      valid_reg <= 1'b1;
      idx_reg   <= '0;
    end else if (valid_reg && ready) begin
      if (idx_reg == LAST_IDX) begin
        valid_reg <= 1'b0;
        idx_reg   <= '0;
      end else begin
        idx_reg <= idx_reg + 7'd1;
      end
    end
  end

endmodule

// File: rtl/pipe_run_ctrl.sv
// Pipeline run controller: loads a program into instruction memory, runs or
// single-steps the pipeline, drains it on halt/stop, and sequences a
// register/data dump.
// Optional feature: define PIPE_CYCLE_CNT_EN to add o_cycle_count, a
// saturating count of cycles with o_pipe_en=1 (cleared on reset and LOAD).
// Ports:
//   i_clk, i_rst                    : clock, synchronous active-high reset
//   i_cmd_valid, i_cmd, o_cmd_ready : command handshake (codes in pipe_ctrl_pkg)
//   i_load_valid, i_load_data       : program words while loading
//   o_inst_we, o_inst_addr, o_inst_data : instruction-memory write port
//   i_if_id_instr                   : instruction currently in IF/ID
//   o_pipe_en                       : pipeline clock enable
//   o_dump_valid, o_dump_idx, i_dump_ready : dump index stream
//   o_busy, o_halted, o_state       : status
module pipe_run_ctrl
  import pipe_ctrl_pkg::*;
  #(
    parameter int                SIZE            = 32,
    parameter int                MAX_INSTRUCTION = 64,
    parameter int                DRAIN_CYCLES    = 4,
    parameter int                DUMP_WORDS      = 96,
    parameter logic [SIZE-1:0]   HALT_WORD       = HALT_WORD_DEFAULT
  )
  (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_cmd_valid,
    input  logic [2:0]      i_cmd,
    output logic            o_cmd_ready,
    input  logic            i_load_valid,
    input  logic [SIZE-1:0] i_load_data,
    output logic            o_inst_we,
    output logic [SIZE-1:0] o_inst_addr,
    output logic [SIZE-1:0] o_inst_data,
    input  logic [SIZE-1:0] i_if_id_instr,
    output logic            o_pipe_en,
    output logic            o_dump_valid,
    output logic [6:0]      o_dump_idx,
    input  logic            i_dump_ready,
    output logic            o_busy,
    output logic            o_halted,
    output logic [2:0]      o_state
`ifdef PIPE_CYCLE_CNT_EN
    ,
    output logic [31:0]     o_cycle_count
`endif
  );

  localparam int CNT_W   = $clog2(MAX_INSTRUCTION + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_e              state_reg;
  logic                busy_reg;
  logic                ready_reg;
  logic                pipe_en_reg;
  logic                halted_reg;
  logic                halt_pend_reg;  // drain was triggered by the halt word
  logic [CNT_W-1:0]    count_reg;
  logic [DRAIN_W-1:0]  drain_cnt_reg;
  logic                we_reg;
  logic [SIZE-1:0]     addr_reg;
  logic [SIZE-1:0]     data_reg;

  logic cmd_fire;
  logic load_accept;
  logic dump_start;
  logic dump_done;
  logic halt_seen;

  assign cmd_fire    = i_cmd_valid && ready_reg;
  assign load_accept = cmd_fire && (state_reg == ST_IDLE) && (i_cmd == CMD_LOAD);
  assign dump_start  = cmd_fire && (state_reg == ST_IDLE) && (i_cmd == CMD_DUMP);
  assign halt_seen   = (i_if_id_instr == HALT_WORD);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg                             <= ST_IDLE;
      {busy_reg, ready_reg, pipe_en_reg}    <= state_flags(ST_IDLE);
      halted_reg                            <= 1'b0;
      halt_pend_reg                         <= 1'b0;
      count_reg                             <= '0;
      drain_cnt_reg                         <= '0;
      we_reg                                <= 1'b0;
      addr_reg                              <= '0;
      data_reg                              <= '0;
    end else begin
      we_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (cmd_fire) begin
            case (i_cmd)
              CMD_LOAD: begin
                state_reg                          <= ST_LOAD;
                {busy_reg, ready_reg, pipe_en_reg} <= state_flags(ST_LOAD);
                count_reg                          <= '0;
                halted_reg                         <= 1'b0;
              end
              CMD_RUN: begin
                if (!halted_reg) begin
                  state_reg                          <= ST_RUN;
                  {busy_reg, ready_reg, pipe_en_reg} <= state_flags(ST_RUN);
                end
              end
              CMD_STEP: begin
                if (!halted_reg) begin
                  state_reg                          <= ST_STEP;
                  {busy_reg, ready_reg, pipe_en_reg} <= state_flags(ST_STEP);
                end
              end
              CMD_DUMP: begin
                state_reg                          <= ST_DUMP;
                {busy_reg, ready_reg, pipe_en_reg} <= state_flags(ST_DUMP);
              end
              default: ;
            endcase
          end
        end

        ST_LOAD: begin
          if (i_load_valid) begin
            we_reg    <= 1'b1;
            addr_reg  <= SIZE'(count_reg) << 2;
            data_reg  <= i_load_data;
            count_reg <= count_reg + 1'b1;
            // The halt word itself is written; the load ends with it.
            if ((i_load_data == HALT_WORD) ||
                (count_reg == CNT_W'(MAX_INSTRUCTION - 1))) begin
              state_reg                          <= ST_IDLE;
              {busy_reg, ready_reg, pipe_en_reg} <= state_flags(ST_IDLE);
            end
          end
        end

        ST_RUN: begin
          // Halt takes priority over a simultaneous STOP.
          if (halt_seen) begin
            state_reg                          <= ST_DRAIN;
            {busy_reg, ready_reg, pipe_en_reg} <= state_flags(ST_DRAIN);
            halt_pend_reg                      <= 1'b1;
            drain_cnt_reg                      <= '0;
          end else if (cmd_fire && (i_cmd == CMD_STOP)) begin
            state_reg                          <= ST_DRAIN;
            {busy_reg, ready_reg, pipe_en_reg} <= state_flags(ST_DRAIN);
            halt_pend_reg                      <= 1'b0;
            drain_cnt_reg                      <= '0;
          end
        end

        ST_STEP: begin
          if (halt_seen) begin
            state_reg                          <= ST_DRAIN;
            {busy_reg, ready_reg, pipe_en_reg} <= state_flags(ST_DRAIN);
            halt_pend_reg                      <= 1'b1;
            drain_cnt_reg                      <= '0;
          end else begin
            state_reg                          <= ST_IDLE;
            {busy_reg, ready_reg, pipe_en_reg} <= state_flags(ST_IDLE);
          end
        end

        ST_DRAIN: begin
          if (drain_cnt_reg == DRAIN_W'(DRAIN_CYCLES - 1)) begin
            state_reg                          <= ST_IDLE;
            {busy_reg, ready_reg, pipe_en_reg} <= state_flags(ST_IDLE);
            halted_reg                         <= halt_pend_reg;
            halt_pend_reg                      <= 1'b0;
            drain_cnt_reg                      <= '0;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + 1'b1;
          end
        end

        ST_DUMP: begin
          if (dump_done) begin
            state_reg                          <= ST_IDLE;
            {busy_reg, ready_reg, pipe_en_reg} <= state_flags(ST_IDLE);
          end
        end

        default: begin
          state_reg                          <= ST_IDLE;
          {busy_reg, ready_reg, pipe_en_reg} <= state_flags(ST_IDLE);
        end
      endcase
    end
  end

  dump_seq #(.DUMP_WORDS(DUMP_WORDS)) u_dump_seq (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .start (dump_start),
    .ready (i_dump_ready),
    .valid (o_dump_valid),
    .idx   (o_dump_idx),
    .done  (dump_done)
  );

`ifdef PIPE_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_reg;

  // Counts the registered enable, so the total matches the cycles the
  // pipeline actually saw o_pipe_en high.
  always_ff @(posedge i_clk) begin
    if (i_rst || load_accept) begin
      cycle_cnt_reg <= '0;
    end else if (pipe_en_reg && !(&cycle_cnt_reg)) begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
    end
  end

  assign o_cycle_count = cycle_cnt_reg;
`else
  logic unused_load_accept;
  assign unused_load_accept = load_accept;
`endif

  assign o_cmd_ready = ready_reg;
  assign o_inst_we   = we_reg;
  assign o_inst_addr = addr_reg;
  assign o_inst_data = data_reg;
  assign o_pipe_en   = pipe_en_reg;
  assign o_busy      = busy_reg;
  assign o_halted    = halted_reg;
  assign o_state     = state_reg;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Scoreboard bench for pipe_run_ctrl. Stimulus pushes expected instruction
// writes, dump indices and pipeline-enable bursts into queues; a monitor
// pops and compares them as the DUT presents them.
module tb_pipe_run_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'd0;
  logic        cmd_ready;
  logic        load_valid = 1'b0;
  logic [31:0] load_data = '0;
  logic        inst_we;
  logic [31:0] inst_addr;
  logic [31:0] inst_data;
  logic [31:0] if_id_instr = '0;
  logic        pipe_en;
  logic        dump_valid;
  logic [6:0]  dump_idx;
  logic        dump_ready = 1'b0;
  logic        busy;
  logic        halted;
  logic [2:0]  state;
`ifdef PIPE_CYCLE_CNT_EN
  logic [31:0] cycle_count;
`endif

  always #5 clk = ~clk;

  pipe_run_ctrl dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cmd_valid   (cmd_valid),
    .i_cmd         (cmd),
    .o_cmd_ready   (cmd_ready),
    .i_load_valid  (load_valid),
    .i_load_data   (load_data),
    .o_inst_we     (inst_we),
    .o_inst_addr   (inst_addr),
    .o_inst_data   (inst_data),
    .i_if_id_instr (if_id_instr),
    .o_pipe_en     (pipe_en),
    .o_dump_valid  (dump_valid),
    .o_dump_idx    (dump_idx),
    .i_dump_ready  (dump_ready),
    .o_busy        (busy),
    .o_halted      (halted),
    .o_state       (state)
`ifdef PIPE_CYCLE_CNT_EN
    ,
    .o_cycle_count (cycle_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          dump_q[$];
  int          burst_len_q[$];
  logic        burst_halt_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  // Monitor: compares every DUT output event against the queued expectations.
  initial begin : monitor
    int run_len;
    int e_len;
    logic e_halt;
    logic [31:0] ea;
    logic [31:0] ed;
    run_len = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (inst_we) begin
          if (wr_addr_q.size() == 0) begin
            chk("unexpected_write_addr", inst_addr, 32'hDEAD_0000);
          end else begin
            ea = wr_addr_q.pop_front();
            ed = wr_data_q.pop_front();
            chk("write_addr", inst_addr, ea);
            chk("write_data", inst_data, ed);
          end
        end
        if (dump_valid && dump_ready) begin
          if (dump_q.size() == 0) begin
            chk("unexpected_dump_idx", 32'(dump_idx), 32'hDEAD_0001);
          end else begin
            chk("dump_idx", 32'(dump_idx), 32'(dump_q.pop_front()));
          end
        end
        if (pipe_en) begin
          run_len++;
        end else if (run_len > 0) begin
          if (burst_len_q.size() == 0) begin
            chk("unexpected_pipe_burst", 32'(run_len), 32'd0);
          end else begin
            e_len  = burst_len_q.pop_front();
            e_halt = burst_halt_q.pop_front();
            chk("pipe_burst_len", 32'(run_len), 32'(e_len));
            chk("halted_after_burst", {31'd0, halted}, {31'd0, e_halt});
          end
          run_len = 0;
        end
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic issue(input logic [2:0] c);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd = c;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd = 3'd0;
  endtask

  task automatic idle_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // RUN for k cycles; in cycle k optionally present STOP and/or the halt word.
  task automatic run_then(input int k, input bit do_stop, input bit do_halt);
    issue(CMD_RUN);
    repeat (k - 1) @(posedge clk);
    #1;
    if (do_stop) begin
      cmd_valid = 1'b1;
      cmd = CMD_STOP;
    end
    if (do_halt) if_id_instr = HALT;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd = 3'd0;
    if_id_instr = 32'h0000_0013;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] words [4];
    bit done_flag;
    words[0] = 32'h2001_0005;
    words[1] = 32'h2002_0003;
    words[2] = HALT;
    words[3] = 32'h2003_0001;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_pipe_en", {31'd0, pipe_en}, 32'd0);
    chk("reset_dump_valid", {31'd0, dump_valid}, 32'd0);
`ifdef PIPE_CYCLE_CNT_EN
    chk("reset_cycle_count", cycle_count, 32'd0);
`endif

    // Three-word program ending in the halt word; the fourth word is dropped.
    for (int i = 0; i < 3; i++) begin
      wr_addr_q.push_back(32'(4 * i));
      wr_data_q.push_back(words[i]);
    end
    issue(CMD_LOAD);
    chk("load_state", 32'(state), 32'd1);
    chk("load_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data = words[i];
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    idle_wait(2);
    chk("load3_end_state", 32'(state), 32'd0);

    // Three single steps.
    for (int i = 0; i < 3; i++) begin
      burst_len_q.push_back(1);
      burst_halt_q.push_back(1'b0);
      issue(CMD_STEP);
      chk("step_state", 32'(state), 32'd3);
      idle_wait(2);
    end
`ifdef PIPE_CYCLE_CNT_EN
    chk("step_cycle_count", cycle_count, 32'd3);
`endif

    // 70 offered words, only 64 written.
    for (int i = 0; i < 64; i++) begin
      wr_addr_q.push_back(32'(4 * i));
      wr_data_q.push_back(32'h1000_0000 + 32'(i));
    end
    issue(CMD_LOAD);
    for (int i = 0; i < 70; i++) begin
      load_valid = 1'b1;
      load_data = 32'h1000_0000 + 32'(i);
      @(posedge clk); #1;
    end
    load_valid = 1'b0;
    idle_wait(2);
    chk("load70_end_state", 32'(state), 32'd0);
    chk("load70_last_addr", inst_addr, 32'd252);
`ifdef PIPE_CYCLE_CNT_EN
    chk("load_clears_cycle_count", cycle_count, 32'd0);
`endif

    // STOP alone after 6 RUN cycles: 6 + 4 drain, not halted.
    burst_len_q.push_back(10);
    burst_halt_q.push_back(1'b0);
    run_then(6, 1'b1, 1'b0);
    chk("stop_drain_state", 32'(state), 32'd4);
    chk("drain_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    idle_wait(6);
    chk("stop_halted", {31'd0, halted}, 32'd0);

    // STOP and halt together: halt wins.
    burst_len_q.push_back(7);
    burst_halt_q.push_back(1'b1);
    run_then(3, 1'b1, 1'b1);
    idle_wait(6);
    chk("stop_halt_halted", {31'd0, halted}, 32'd1);

    // LOAD clears halted; one-word program.
    wr_addr_q.push_back(32'd0);
    wr_data_q.push_back(HALT);
    issue(CMD_LOAD);
    chk("load_clears_halted", {31'd0, halted}, 32'd0);
    load_valid = 1'b1;
    load_data = HALT;
    @(posedge clk); #1;
    load_valid = 1'b0;
    idle_wait(2);

    // Halt word at RUN cycle 10: 10 + 4 enable cycles, then halted.
    burst_len_q.push_back(14);
    burst_halt_q.push_back(1'b1);
    run_then(10, 1'b0, 1'b1);
    idle_wait(6);
    chk("run_halt_halted", {31'd0, halted}, 32'd1);
    issue(CMD_RUN);
    chk("run_ignored_when_halted", 32'(state), 32'd0);
    issue(CMD_STEP);
    chk("step_ignored_when_halted", 32'(state), 32'd0);
    idle_wait(3);

    // Full dump with ready toggling.
    for (int i = 0; i < 96; i++) dump_q.push_back(i);
    dump_ready = 1'b0;
    issue(CMD_DUMP);
    chk("dump_state", 32'(state), 32'd5);
    chk("dump_first_idx", 32'(dump_idx), 32'd0);
    done_flag = 1'b0;
    for (int c = 0; c < 400 && !done_flag; c++) begin
      dump_ready = ~dump_ready;
      @(posedge clk); #1;
      if (state == 3'd0) done_flag = 1'b1;
    end
    dump_ready = 1'b0;
    chk("dump_finished_in_budget", {31'd0, done_flag}, 32'd1);
    chk("dump_end_valid", {31'd0, dump_valid}, 32'd0);
    chk("dump_queue_drained", 32'(dump_q.size()), 32'd0);

    // Reset in the middle of a dump, at index 40.
    for (int i = 0; i < 40; i++) dump_q.push_back(i);
    issue(CMD_DUMP);
    dump_ready = 1'b1;
    done_flag = 1'b0;
    for (int c = 0; c < 200 && !done_flag; c++) begin
      if (dump_idx == 7'd40) done_flag = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("dump_reached_idx40", {31'd0, done_flag}, 32'd1);
    dump_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midreset_state", 32'(state), 32'd0);
    chk("midreset_dump_valid", {31'd0, dump_valid}, 32'd0);
    chk("midreset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;
    idle_wait(3);

    chk("write_queue_empty", 32'(wr_addr_q.size()), 32'd0);
    chk("dump_queue_empty", 32'(dump_q.size()), 32'd0);
    chk("burst_queue_empty", 32'(burst_len_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_run_ctrl.md
PIPE_RUN_CTRL -- requirements
Module: pipe_run_ctrl

Interface
REQ-001 Parameters SHALL be: SIZE, default 32, datapath word width; MAX_INSTRUCTION, default 64, instruction-memory depth in words; DRAIN_CYCLES, default 4, pipeline drain length; DUMP_WORDS, default 96, registers plus data words streamed per dump; HALT_WORD, default 32'hFFFFFFFF, halt encoding.
REQ-002 Clock and reset SHALL be: i_clk, i_rst, synchronous, active-high.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
- i_clk in 1: clock.
- i_rst in 1: synchronous active-high reset.
- i_cmd_valid in 1: command strobe.
- i_cmd in 3: command code; 0 NOP, 1 LOAD, 2 RUN, 3 STEP, 4 STOP, 5 DUMP.
- o_cmd_ready out 1: controller accepts a command.
- i_load_valid in 1: load word strobe.
- i_load_data in SIZE: instruction word to load.
- o_inst_we out 1: instruction-memory write enable.
- o_inst_addr out SIZE: byte write address.
- o_inst_data out SIZE: write data.
- i_if_id_instr in SIZE: instruction in the IF/ID register.
- o_pipe_en out 1: pipeline clock enable.
- o_dump_valid out 1: dump index valid.
- o_dump_idx out 7: dump word index.
- i_dump_ready in 1: dump index consumed.
- o_busy out 1: controller is not in IDLE.
- o_halted out 1: the program has executed HALT_WORD.
- o_state out 3: state encoding, for debug.

Function
REQ-004 States SHALL be IDLE=0, LOAD=1, RUN=2, STEP=3, DRAIN=4, DUMP=5.
REQ-005 o_cmd_ready SHALL be 1 only in IDLE, or in RUN for STOP; a command SHALL be accepted when i_cmd_valid and o_cmd_ready are both 1.
REQ-006 Transitions from IDLE: LOAD -> LOAD, clearing the word count and o_halted; RUN -> RUN; STEP -> STEP; DUMP -> DUMP. NOP, STOP and undefined codes SHALL be ignored.
REQ-007 RUN and STEP SHALL be ignored while o_halted=1.
REQ-008 In LOAD, each i_load_valid SHALL produce o_inst_we=1 in the next cycle, with o_inst_addr=4*count and o_inst_data=i_load_data; count then increments.
REQ-009 LOAD SHALL exit to IDLE after writing a word equal to HALT_WORD, or after MAX_INSTRUCTION words, whichever comes first; no further write SHALL occur.
REQ-010 In RUN, o_pipe_en SHALL be 1 every cycle.
REQ-011 RUN SHALL go to DRAIN when i_if_id_instr==HALT_WORD, which sets o_halted at DRAIN exit, or when STOP is accepted; HALT SHALL win if both occur in the same cycle.
REQ-012 DRAIN SHALL hold o_pipe_en=1 for exactly DRAIN_CYCLES cycles, then return to IDLE.
REQ-013 STEP SHALL assert o_pipe_en for exactly one cycle, then return to IDLE. If i_if_id_instr==HALT_WORD in that cycle, it SHALL go to DRAIN instead.
REQ-014 In DUMP, o_dump_idx SHALL start at 0 with o_dump_valid=1, and advance only on cycles where o_dump_valid and i_dump_ready are both 1.
REQ-015 DUMP SHALL return to IDLE after index DUMP_WORDS-1 is accepted; the index SHALL NOT wrap.
REQ-016 o_pipe_en SHALL be 0 in IDLE, LOAD and DUMP.
REQ-017 o_busy SHALL be 1 when o_state!=IDLE.
REQ-018 All outputs SHALL be registered, with latency of one cycle from the triggering input.

Reset
REQ-019 On i_rst, the state SHALL go to IDLE and all outputs SHALL be 0 (o_cmd_ready=1, o_state=0) in the next cycle. This includes a reset mid-LOAD, mid-RUN, mid-DRAIN or mid-DUMP, and all counters SHALL clear.

Configuration
REQ-020 With PIPE_CYCLE_CNT_EN defined, the block SHALL add output o_cycle_count, 32 bits, counting cycles with o_pipe_en=1. The counter SHALL clear on reset and on an accepted LOAD, and SHALL saturate at all-ones.
REQ-021 Without PIPE_CYCLE_CNT_EN, the port and the counter SHALL NOT exist; all other behaviour SHALL be identical.

Structure
REQ-022 The command codes, state encodings and HALT_WORD default SHALL live in the shared package pipe_ctrl_pkg.
REQ-023 The dump index sequencer SHALL be one sub-module, dump_seq, with handshake counter, start and done.

Verification
REQ-024 LOAD, then 3 words 0x20010005, 0x20020003, 0xFFFFFFFF -> writes at addr 0,4,8, then IDLE, with no write for a 4th word.
REQ-025 LOAD with 70 non-halt words -> exactly 64 writes with last addr 252, then IDLE.
REQ-026 RUN, with i_if_id_instr=HALT_WORD at cycle 10 -> o_pipe_en high 10+4 cycles, o_halted=1, then RUN ignored.
REQ-027 RUN, then STOP and HALT in the same cycle -> o_halted=1; STOP alone -> o_halted=0 after 4 drain cycles.
REQ-028 STEP x3 -> exactly 3 single-cycle o_pipe_en pulses (o_cycle_count=3 when the macro is defined).
REQ-029 DUMP with i_dump_ready toggling every other cycle -> indices 0..95 each exactly once, then IDLE; i_rst at index 40 -> IDLE and o_dump_valid=0 in the next cycle.
